mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single-ported word memory.
// Optional read-modify-write for partial stores: define MEM_ARB_RMW_EN.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        I_ACC = 3'd1,
        D_ACC = 3'd2,
`ifdef MEM_ARB_RMW_EN
        D_RD  = 3'd3,
        D_WR  = 3'd4,
`endif
        ACK   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        d_err_q, d_err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        grant_d;

`ifdef MEM_ARB_RMW_EN
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merged;

    always_comb begin
        merged = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            merged[8*n +: 8] = wstrb_q[n] ? wdata_q[8*n +: 8] : mem_rdata[8*n +: 8];
        end
    end
`endif

    // Byte offsets never reach memory; the bus is word-addressed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    // Outputs are registered, so each one is computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        we_d        = we_q;
        wstrb_d     = wstrb_q;
`ifdef MEM_ARB_RMW_EN
        wdata_d     = wdata_q;
`endif
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        grant_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_d  = d_req && !(i_req && last_d_q);
                    last_d_d = grant_d;
                    if (grant_d) begin
                        we_d    = d_we;
                        wstrb_d = d_wstrb;
`ifdef MEM_ARB_RMW_EN
                        wdata_d = d_wdata;
`endif
                        if (d_we && d_wstrb == 4'h0) begin
                            state_d = ACK;
                            d_ack_d = 1'b1;
                        end else if (d_we && d_wstrb != 4'hF) begin
`ifdef MEM_ARB_RMW_EN
                            state_d    = D_RD;
                            mem_read_d = 1'b1;
                            mem_addr_d = {d_addr[31:2], 2'b00};
`else
                            state_d = D_ACC;
`endif
                        end else begin
                            state_d     = D_ACC;
                            mem_read_d  = !d_we;
                            mem_write_d = d_we;
                            mem_addr_d  = {d_addr[31:2], 2'b00};
                            if (d_we) mem_wdata_d = d_wdata;
                        end
                    end else begin
                        state_d    = I_ACC;
                        mem_read_d = 1'b1;
                        mem_addr_d = {i_addr[31:2], 2'b00};
                    end
                end
            end
            I_ACC: begin
                i_rdata_d = mem_rdata;
                i_ack_d   = 1'b1;
                state_d   = ACK;
            end
            D_ACC: begin
                if (!we_q) d_rdata_d = mem_rdata;
                // Only reachable with a partial strobe when RMW is compiled out.
                d_err_d = we_q && (wstrb_q != 4'h0) && (wstrb_q != 4'hF);
                d_ack_d = 1'b1;
                state_d = ACK;
            end
`ifdef MEM_ARB_RMW_EN
            D_RD: begin
                mem_write_d = 1'b1;
                mem_addr_d  = mem_addr_q;
                mem_wdata_d = merged;
                state_d     = D_WR;
            end
            D_WR: begin
                d_ack_d = 1'b1;
                state_d = ACK;
            end
`endif
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            we_q        <= 1'b0;
            wstrb_q     <= '0;
`ifdef MEM_ARB_RMW_EN
            wdata_q     <= '0;
`endif
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
`ifdef MEM_ARB_RMW_EN
            wdata_q     <= wdata_d;
`endif
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 16-word memory model; honours MEM_ARB_RMW_EN.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory model: combinational read, write on clock edge, plus a bench preload port.
    logic [31:0] mem [0:15];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
        if (pl_en) mem[pl_idx] <= pl_data;
    end

    int total = 0;
    int bad = 0;
    int both_cnt = 0;
    int dup_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        pl_en = 1'b1;
        pl_idx = idx;
        pl_data = data;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i_ack"}, {31'd0, i_ack}, 32'd0);
        check({tag, "_d_ack"}, {31'd0, d_ack}, 32'd0);
        check({tag, "_d_err"}, {31'd0, d_err}, 32'd0);
        check({tag, "_i_rdata"}, i_rdata, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
        check({tag, "_mem_rd"}, {31'd0, mem_read}, 32'd0);
        check({tag, "_mem_wr"}, {31'd0, mem_write}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    // Runs one already-raised request until its ack (bounded), then drops it and returns to IDLE.
    task automatic run_txn(input bit is_d, output int lat, output int nrd, output int nwr,
                           output int rd_at, output int wr_at, output logic err);
        lat = 0; nrd = 0; nwr = 0; rd_at = 0; wr_at = 0; err = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (mem_read) begin nrd++; if (rd_at == 0) rd_at = c; end
            if (mem_write) begin nwr++; if (wr_at == 0) wr_at = c; end
            if (mem_read && mem_write) both_cnt++;
            if (i_ack && d_ack) dup_cnt++;
            if ((is_d && d_ack) || (!is_d && i_ack)) begin
                lat = c;
                err = d_err;
                break;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
    endtask

    int lat, nrd, nwr, rd_at, wr_at;
    logic err;
    int n_acks;
    logic [2:0] seq;
    logic [31:0] ack_data [0:2];

    initial begin
        rst_n = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        preload(4'd1, 32'hDEADBEEF);
        preload(4'd4, 32'h11223344);

        // Instruction fetch timing
        i_req = 1'b1; i_addr = 32'h0000_0104;
        tick();
        check("if_c1_rd", {31'd0, mem_read}, 32'd1);
        check("if_c1_addr", mem_addr, 32'h0000_0104);
        check("if_c1_ack", {31'd0, i_ack}, 32'd0);
        tick();
        check("if_c2_ack", {31'd0, i_ack}, 32'd1);
        check("if_c2_data", i_rdata, 32'hDEADBEEF);
        check("if_c2_rd", {31'd0, mem_read}, 32'd0);
        i_req = 1'b0;
        tick();
        check("if_ack_pulse", {31'd0, i_ack}, 32'd0);

        // Partial store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hAABBCCDD; d_wstrb = 4'b0101;
        run_txn(1'b1, lat, nrd, nwr, rd_at, wr_at, err);
`ifdef MEM_ARB_RMW_EN
        check("ps_lat", lat, 3);
        check("ps_rd_at", rd_at, 1);
        check("ps_wr_at", wr_at, 2);
        check("ps_nwr", nwr, 1);
        check("ps_err", {31'd0, err}, 32'd0);
        check("ps_mem", mem[4], 32'h11BB33DD);
`else
        check("ps_lat", lat, 2);
        check("ps_nrd", nrd, 0);
        check("ps_nwr", nwr, 0);
        check("ps_err", {31'd0, err}, 32'd1);
        check("ps_mem", mem[4], 32'h11223344);
`endif

        // Full store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h14; d_wdata = 32'hCAFEF00D; d_wstrb = 4'hF;
        run_txn(1'b1, lat, nrd, nwr, rd_at, wr_at, err);
        check("fs_lat", lat, 2);
        check("fs_nrd", nrd, 0);
        check("fs_nwr", nwr, 1);
        check("fs_err", {31'd0, err}, 32'd0);
        check("fs_mem", mem[5], 32'hCAFEF00D);

        // Zero-strobe store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h14; d_wdata = 32'h0; d_wstrb = 4'h0;
        run_txn(1'b1, lat, nrd, nwr, rd_at, wr_at, err);
        check("zs_lat", lat, 1);
        check("zs_nrd", nrd, 0);
        check("zs_nwr", nwr, 0);
        check("zs_err", {31'd0, err}, 32'd0);
        check("zs_mem", mem[5], 32'hCAFEF00D);

        // Load with an unaligned byte address
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h17; d_wstrb = 4'h0;
        run_txn(1'b1, lat, nrd, nwr, rd_at, wr_at, err);
        check("ld_lat", lat, 2);
        check("ld_nrd", nrd, 1);
        check("ld_data", d_rdata, 32'hCAFEF00D);

        // Held conflicting requests from reset: D, I, D
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        preload(4'd2, 32'h22222222);
        preload(4'd3, 32'h33333333);
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC;
        n_acks = 0; seq = '0;
        for (int c = 0; c < 30 && n_acks < 3; c++) begin
            tick();
            if (i_ack && d_ack) dup_cnt++;
            if (i_ack || d_ack) begin
                seq[n_acks] = d_ack;
                ack_data[n_acks] = d_ack ? d_rdata : i_rdata;
                n_acks++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        check("arb_n_acks", n_acks, 3);
        check("arb_order", {29'd0, seq}, 32'b101);
        check("arb_data0", ack_data[0], 32'h33333333);
        check("arb_data1", ack_data[1], 32'h22222222);
        check("arb_data2", ack_data[2], 32'h33333333);
        tick(); tick(); tick();
        check("arb_quiet_i", {31'd0, i_ack}, 32'd0);
        check("arb_quiet_d", {31'd0, d_ack}, 32'd0);

        // Reset mid-access, then reissue
        preload(4'd4, 32'h11223344);
`ifdef MEM_ARB_RMW_EN
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hAABBCCDD; d_wstrb = 4'b0101;
        tick(); tick();
        check("rst_in_dwr", {31'd0, mem_write}, 32'd1);
`else
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14; d_wstrb = 4'h0;
        tick();
        check("rst_in_dacc", {31'd0, mem_read}, 32'd1);
`endif
        rst_n = 1'b0;
        tick();
        check_all_zero("rst_abort");
        rst_n = 1'b1;
        run_txn(1'b1, lat, nrd, nwr, rd_at, wr_at, err);
`ifdef MEM_ARB_RMW_EN
        check("reissue_lat", lat, 3);
        check("reissue_err", {31'd0, err}, 32'd0);
        check("reissue_mem", mem[4], 32'h11BB33DD);
`else
        check("reissue_lat", lat, 2);
        check("reissue_data", d_rdata, 32'hCAFEF00D);
`endif

        check("rd_wr_exclusive", both_cnt, 0);
        check("single_ack", dup_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
